spis_reg_bridge: RTL



---
 rtl/spis_reg_bridge_if.sv | 21 ++
 rtl/spis_reg_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spis_reg_bridge_if.sv
// Register bus between the SPI bridge (master) and the register crossbar (slave).
// Carries req/ack handshake, write flag, address, byte enables, write and read data.
interface spis_reg_bridge_if;
   logic        reg_req;
   logic        reg_wr;
   logic [31:0] reg_addr;
   logic [3:0]  reg_be;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        reg_ack;

   modport master (
      output reg_req, reg_wr, reg_addr, reg_be, reg_wdata,
      input  reg_rdata, reg_ack
   );

   modport slave (
      input  reg_req, reg_wr, reg_addr, reg_be, reg_wdata,
      output reg_rdata, reg_ack
   );
endinterface

// File: rtl/spis_reg_bridge.sv
// SPI slave frame decoder that issues one register read/write per frame.
// Ports: mclk/rst; SPI pins spi_clk, spi_sel_n, spi_din, spi_dout, spi_dout_oen;
//        bus = register master side; rd_late_err = sticky late read data flag.
module spis_reg_bridge #(
   parameter int SYNC_STAGES    = 2,
   parameter bit RD_TIMEOUT_ERR = 1'b1
) (
   input  logic              mclk,
   input  logic              rst,
   input  logic              spi_clk,
   input  logic              spi_sel_n,
   input  logic              spi_din,
   output logic              spi_dout,
   output logic              spi_dout_oen,
   output logic              rd_late_err,
   spis_reg_bridge_if.master bus
);
   localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE
   } state_t;

   state_t state, state_nx;

   logic [NS-1:0] clk_sync, sel_sync, din_sync;
   logic          clk_hist, sel_hist;
   logic          clk_s, sel_s, din_s;
   logic          rise, fall, frame_start, desel;

   logic [6:0]  cnt, cnt_nx;
   logic [31:0] shift, sh_nx;
   logic        is_rd, cmd_ok;
   logic [3:0]  be_q;
   logic [31:0] addr_q, wdata_q;
   logic        wr_q, pend, cur;
   logic [5:0]  rd_cnt;
   logic [31:0] tx_shift, tx_base;
   logic        new_req, ack_ok, rd_ack;
   logic        iss_wr;
   logic [31:0] iss_addr, iss_wdata;
   logic [3:0]  iss_be;

   always_ff @(posedge mclk) begin
      if (rst) begin
         clk_sync <= '1;
         sel_sync <= '1;
         din_sync <= '0;
         clk_hist <= 1'b1;
         sel_hist <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[NS-2:0], spi_clk};
         sel_sync <= {sel_sync[NS-2:0], spi_sel_n};
         din_sync <= {din_sync[NS-2:0], spi_din};
         clk_hist <= clk_s;
         sel_hist <= sel_s;
      end
   end

   assign clk_s = clk_sync[NS-1];
   assign sel_s = sel_sync[NS-1];
   assign din_s = din_sync[NS-1];

   // clock edges only count while selected; a deselect swallows a same-cycle rise
   assign rise        = clk_s & ~clk_hist & ~sel_s;
   assign fall        = ~clk_s & clk_hist & ~sel_s;
   assign frame_start = ~sel_s & sel_hist;
   assign desel       = sel_s & ~sel_hist;

   assign cnt_nx = cnt + 7'd1;
   assign sh_nx  = {shift[30:0], din_s};
   assign cmd_ok = (sh_nx[7:0] == 8'h10) | (sh_nx[7:4] == 4'h2);
   assign ack_ok = bus.reg_req & bus.reg_ack;
   // read data only belongs to us if the request came from the live frame
   assign rd_ack = ack_ok & ~bus.reg_wr & cur;

   always_ff @(posedge mclk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      new_req      = 1'b0;
      spi_dout_oen = 1'b1;
      unique case (state)
         IDLE: ;
         CMD: begin
            if (rise && cnt_nx == 7'd8)
               state_nx = cmd_ok ? ADDR : IGNORE;
         end
         ADDR: begin
            if (rise && cnt_nx == 7'd40) begin
               state_nx = is_rd ? DUMMY : WDATA;
               new_req  = is_rd;
            end
         end
         WDATA: begin
            if (rise && cnt_nx == 7'd72) begin
               state_nx = DUMMY;
               new_req  = 1'b1;
            end
         end
         DUMMY: begin
            if (rise && cnt_nx == (is_rd ? 7'd48 : 7'd80))
               state_nx = is_rd ? RDATA : IGNORE;
         end
         RDATA: begin
            spi_dout_oen = 1'b0;
            if (rise && cnt_nx == 7'd80)
               state_nx = IGNORE;
         end
         IGNORE: ;
         default: state_nx = IDLE;
      endcase
      if (desel)       state_nx = IDLE;
      if (frame_start) state_nx = CMD;
   end

   // a fresh request bypasses the holding registers; otherwise replay the pending one
   always_comb begin
      iss_wr    = wr_q;
      iss_addr  = addr_q;
      iss_be    = be_q;
      iss_wdata = wdata_q;
      if (new_req) begin
         iss_wr = ~is_rd;
         if (is_rd) iss_addr  = sh_nx;
         else       iss_wdata = sh_nx;
      end
   end

   // late read data is realigned to the bit the master is currently on
   always_comb begin
      tx_base = tx_shift;
      if (rd_ack)
         tx_base = (rd_cnt == 6'd0) ? bus.reg_rdata
                                    : bus.reg_rdata << (rd_cnt - 6'd1);
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         cnt           <= '0;
         shift         <= '0;
         is_rd         <= 1'b0;
         be_q          <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wr_q          <= 1'b0;
         pend          <= 1'b0;
         cur           <= 1'b0;
         rd_cnt        <= '0;
         tx_shift      <= '0;
         spi_dout      <= 1'b0;
         rd_late_err   <= 1'b0;
         bus.reg_req   <= 1'b0;
         bus.reg_wr    <= 1'b0;
         bus.reg_addr  <= '0;
         bus.reg_be    <= '0;
         bus.reg_wdata <= '0;
      end else begin
         if (rise) begin
            cnt   <= cnt_nx;
            shift <= sh_nx;
         end
         if (state == CMD && rise && cnt_nx == 7'd8) begin
            is_rd <= (sh_nx[7:0] == 8'h10);
            be_q  <= (sh_nx[7:0] == 8'h10) ? 4'hF : sh_nx[3:0];
         end
         if (state == ADDR && rise && cnt_nx == 7'd40)
            addr_q <= sh_nx;
         if (new_req) begin
            addr_q  <= iss_addr;
            wdata_q <= iss_wdata;
            wr_q    <= iss_wr;
            pend    <= 1'b1;
         end
         // one request in flight: a new one waits for the old ack
         if (ack_ok) begin
            bus.reg_req <= 1'b0;
         end else if (!bus.reg_req && (pend || new_req)) begin
            bus.reg_req   <= 1'b1;
            bus.reg_wr    <= iss_wr;
            bus.reg_addr  <= iss_addr;
            bus.reg_be    <= iss_be;
            bus.reg_wdata <= iss_wdata;
            pend          <= 1'b0;
            cur           <= 1'b1;
         end
         tx_shift <= tx_base;
         if (state == RDATA && fall) begin
            rd_cnt <= rd_cnt + 6'd1;
            if (rd_cnt == 6'd0) begin
               spi_dout <= tx_base[31];
            end else begin
               tx_shift <= tx_base << 1;
               spi_dout <= tx_base[30];
            end
         end else if (rd_ack && rd_cnt != 6'd0) begin
            spi_dout <= tx_base[31];
         end
         if (RD_TIMEOUT_ERR && rd_ack && rd_cnt != 6'd0)
            rd_late_err <= 1'b1;
         if (desel) begin
            pend <= 1'b0;
            cur  <= 1'b0;
         end
         if (frame_start) begin
            cnt         <= '0;
            shift       <= '0;
            rd_late_err <= 1'b0;
            tx_shift    <= '0;
            rd_cnt      <= '0;
            cur         <= 1'b0;
         end
      end
   end
endmodule
